// File: rtl/checker_pkg.sv
// Shared types and helpers for the end-of-program memory result checker.
package checker_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        CHECK   = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } chk_state_e;

    localparam int unsigned WORD_BYTES = 4;

    // Byte address of answer word idx.
    function automatic logic [31:0] ans_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + idx * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/chk_watchdog.sv
// Cycle watchdog: counts while enabled, saturates and fires at MAX_CYCLES-1.
module chk_watchdog #(
    parameter int unsigned MAX_CYCLES = 300000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_fire_c
);

    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Holding at LAST keeps the fire level up if the owner survives one firing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_fire_c = i_en && (r_cnt == LAST);

endmodule

// File: rtl/mem_result_checker.sv
// Compares answer words read from NUM_SRC sources against a golden table once the CPU reaches DONE_PC.
// Optional mismatch trace port enabled by defining CHECKER_TRACE_EN.
module mem_result_checker
    import checker_pkg::*;
#(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned NUM_WORDS     = 100,
    parameter int unsigned NUM_SRC       = 3,
    parameter logic [ADDR_W-1:0] ANSWER_START = ADDR_W'(32'h9000),
    parameter logic [ADDR_W-1:0] DONE_PC      = ADDR_W'(32'h1c),
    parameter int unsigned MAX_CYCLES    = 300000,
    localparam int unsigned IDX_W        = $clog2(NUM_WORDS),
    localparam int unsigned CNT_W        = $clog2(NUM_WORDS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           pc_i,
    input  logic                        gold_we,
    input  logic [IDX_W-1:0]            gold_idx,
    input  logic [DATA_W-1:0]           gold_data,
    output logic                        rd_req,
    output logic [ADDR_W-1:0]           rd_addr,
    output logic [IDX_W-1:0]            rd_idx,
    input  logic                        rd_valid,
    input  logic [NUM_SRC*DATA_W-1:0]   rd_data,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        timeout,
    output logic [CNT_W-1:0]            err_cnt,
    output logic                        mm_valid,
    output logic [IDX_W-1:0]            mm_idx,
    output logic [DATA_W-1:0]           mm_got,
    output logic [DATA_W-1:0]           mm_exp
);

    chk_state_e         r_state, w_state_nxt;
    logic [DATA_W-1:0]  r_gold [NUM_WORDS];
    logic [CNT_W-1:0]   r_gold_num, r_err_cnt, w_err_nxt, w_gold_len;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_rd_req, r_busy, r_done, r_pass, r_timeout;
    logic [DATA_W-1:0]  w_gold_rd;
    logic               w_gold_wr, w_match, w_accept, w_last, w_miss;
    logic               w_wd_en, w_fire;

    assign w_gold_wr  = gold_we && (r_state == RUN) && (32'(gold_idx) < NUM_WORDS);
    assign w_gold_len = CNT_W'(gold_idx) + CNT_W'(1);
    assign w_gold_rd  = r_gold[r_idx];
    assign w_accept   = (r_state == CHECK) && rd_valid;
    assign w_last     = (CNT_W'(r_idx) + CNT_W'(1)) == r_gold_num;
    assign w_miss     = w_accept && !w_match;
    assign w_wd_en    = (r_state == RUN) || (r_state == CHECK);

    // Golden storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_gold_wr) begin
            r_gold[gold_idx] <= gold_data;
        end
    end

    // A word passes if any source returns the golden value.
    always_comb begin
        w_match = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (rd_data[s*DATA_W +: DATA_W] == w_gold_rd) begin
                w_match = 1'b1;
            end
        end
    end

    chk_watchdog #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst),
        .i_clr    (!w_wd_en),
        .i_en     (w_wd_en),
        .o_fire_c (w_fire)
    );

    // Next state; reaching DONE_PC or finishing the last word beats the watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = r_err_cnt;
        case (r_state)
            RUN: begin
                if (pc_i == DONE_PC) begin
                    w_state_nxt = (r_gold_num == '0) ? DONE : CHECK;
                end else if (w_fire) begin
                    w_state_nxt = TIMEOUT;
                end
            end
            CHECK: begin
                if (w_miss) begin
                    w_err_nxt = r_err_cnt + CNT_W'(1);
                end
                if (w_accept) begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
                if (w_fire && !(w_accept && w_last)) begin
                    w_state_nxt = TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_idx      <= '0;
            r_err_cnt  <= '0;
            r_gold_num <= '0;
            r_rd_req   <= 1'b0;
            r_rd_addr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_err_cnt <= w_err_nxt;
            if (w_gold_wr && (w_gold_len > r_gold_num)) begin
                r_gold_num <= w_gold_len;
            end
            r_rd_req  <= (w_state_nxt == CHECK);
            r_busy    <= (w_state_nxt == CHECK);
            r_rd_addr <= (w_state_nxt == CHECK)
                         ? ADDR_W'(ans_addr(32'(ANSWER_START), 32'(w_idx_nxt))) : '0;
            r_done    <= (w_state_nxt == DONE) || (w_state_nxt == TIMEOUT);
            r_pass    <= (w_state_nxt == DONE) && (w_err_nxt == '0);
            r_timeout <= (w_state_nxt == TIMEOUT);
        end
    end

    assign rd_req  = r_rd_req;
    assign rd_addr = r_rd_addr;
    assign rd_idx  = r_idx;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign timeout = r_timeout;
    assign err_cnt = r_err_cnt;

`ifdef CHECKER_TRACE_EN
    logic              r_mm_valid;
    logic [IDX_W-1:0]  r_mm_idx;
    logic [DATA_W-1:0] r_mm_got, r_mm_exp;

    // Captures source 0 and the golden value of each failing word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mm_valid <= 1'b0;
            r_mm_idx   <= '0;
            r_mm_got   <= '0;
            r_mm_exp   <= '0;
        end else begin
            r_mm_valid <= w_miss;
            if (w_miss) begin
                r_mm_idx <= r_idx;
                r_mm_got <= rd_data[DATA_W-1:0];
                r_mm_exp <= w_gold_rd;
            end
        end
    end

    assign mm_valid = r_mm_valid;
    assign mm_idx   = r_mm_idx;
    assign mm_got   = r_mm_got;
    assign mm_exp   = r_mm_exp;
`else
    assign mm_valid = 1'b0;
    assign mm_idx   = '0;
    assign mm_got   = '0;
    assign mm_exp   = '0;
`endif

endmodule

// File: tb/tb_mem_result_checker.sv
// Randomized self-checking bench for mem_result_checker against a word-level reference model.
module tb_mem_result_checker;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 32;
    localparam int unsigned NW   = 100;
    localparam int unsigned NS   = 3;
    localparam int unsigned MAXC = 50;
    localparam int unsigned IW   = $clog2(NW);
    localparam int unsigned CW   = $clog2(NW + 1);
    localparam logic [31:0] ANS  = 32'h9000;
    localparam logic [31:0] DPC  = 32'h1c;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     pc_i;
    logic              gold_we;
    logic [IW-1:0]     gold_idx;
    logic [DW-1:0]     gold_data;
    logic              rd_req;
    logic [AW-1:0]     rd_addr;
    logic [IW-1:0]     rd_idx;
    logic              rd_valid;
    logic [NS*DW-1:0]  rd_data;
    logic              busy, done, pass, timeout;
    logic [CW-1:0]     err_cnt;
    logic              mm_valid;
    logic [IW-1:0]     mm_idx;
    logic [DW-1:0]     mm_got, mm_exp;

    mem_result_checker #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW), .NUM_SRC(NS),
        .ANSWER_START(ANS), .DONE_PC(DPC), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i),
        .gold_we(gold_we), .gold_idx(gold_idx), .gold_data(gold_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt),
        .mm_valid(mm_valid), .mm_idx(mm_idx), .mm_got(mm_got), .mm_exp(mm_exp)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release.
    int edges;
    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] gold [16];
    logic [31:0] src  [16][NS];
    int          n_words;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        gold_we   = 1'b0;
        gold_idx  = '0;
        gold_data = '0;
        rd_valid  = 1'b0;
        rd_data   = '0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_rd_req"},   64'(rd_req),   64'd0);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_done"},     64'(done),     64'd0);
        chk({tag, "_pass"},     64'(pass),     64'd0);
        chk({tag, "_timeout"},  64'(timeout),  64'd0);
        chk({tag, "_mm_valid"}, 64'(mm_valid), 64'd0);
        chk({tag, "_err_cnt"},  64'(err_cnt),  64'd0);
        chk({tag, "_rd_addr"},  64'(rd_addr),  64'd0);
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        pc_i = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Random words; each either matches in one random source or misses everywhere.
    task automatic gen_words(input int n);
        int unsigned k;
        n_words = n;
        for (int i = 0; i < n; i++) begin
            gold[i] = $urandom;
            k = $urandom_range(0, NS);
            for (int s = 0; s < NS; s++) begin
                src[i][s] = $urandom;
                if (src[i][s] == gold[i]) src[i][s] = src[i][s] ^ 32'h1;
            end
            if (k < NS) src[i][k] = gold[i];
        end
    endtask

    task automatic load_gold();
        bit down;
        down = 1'($urandom_range(0, 1));
        for (int j = 0; j < n_words; j++) begin
            int i;
            i = down ? (n_words - 1 - j) : j;
            pc_i      = $urandom;
            if (pc_i == DPC) pc_i = pc_i + 32'd4;
            gold_we   = 1'b1;
            gold_idx  = IW'(i);
            gold_data = gold[i];
            @(negedge clk);
        end
        gold_we = 1'b0;
    endtask

    function automatic bit word_hit(input int i);
        for (int s = 0; s < NS; s++) if (src[i][s] == gold[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_errs();
        int e = 0;
        for (int i = 0; i < n_words; i++) if (!word_hit(i)) e++;
        return e;
    endfunction

    // mode 0: normal run, 1: withhold rd_valid, 2: stop after abort_at words.
    task automatic run_check(input int mode, input int abort_at);
        int exp_mm[$];
        int e_idx  = 0;
        int wait_d = -1;
        int errs;
        bit fin    = 1'b0;
        errs = model_errs();
        for (int i = 0; i < n_words; i++) if (!word_hit(i)) exp_mm.push_back(i);
        pc_i = DPC;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(negedge clk);
`ifdef CHECKER_TRACE_EN
            if (mm_valid) begin
                if (exp_mm.size() == 0) begin
                    chk("mm_extra", 64'(mm_idx), 64'hffff);
                end else begin
                    int i;
                    i = exp_mm.pop_front();
                    chk("mm_idx", 64'(mm_idx), 64'(i));
                    chk("mm_got", 64'(mm_got), 64'(src[i][0]));
                    chk("mm_exp", 64'(mm_exp), 64'(gold[i]));
                end
            end
`else
            chk("mm_tied", 64'(mm_valid | (|mm_idx) | (|mm_got) | (|mm_exp)), 64'd0);
`endif
            if (done) begin
                fin = 1'b1;
            end else if (mode == 2 && e_idx >= abort_at) begin
                break;
            end else begin
                rd_valid = 1'b0;
                gold_we  = 1'b0;
                for (int s = 0; s < NS; s++) rd_data[s*DW +: DW] = $urandom;
                if (rd_req) begin
                    if (wait_d < 0) begin
                        chk("rd_idx",  64'(rd_idx),  64'(e_idx));
                        chk("rd_addr", 64'(rd_addr), 64'(ANS + 32'(4 * e_idx)));
                        wait_d = (mode == 1) ? 1000 : int'($urandom_range(0, 2));
                    end else begin
                        chk("rd_addr_hold", 64'(rd_addr), 64'(ANS + 32'(4 * e_idx)));
                    end
                    chk("busy", 64'(busy), 64'd1);
                    if (wait_d == 0) begin
                        rd_valid = 1'b1;
                        for (int s = 0; s < NS; s++) rd_data[s*DW +: DW] = src[e_idx % 16][s];
                        e_idx++;
                        wait_d = -1;
                    end else begin
                        wait_d--;
                    end
                    // Golden writes outside RUN must have no effect.
                    if ($urandom_range(0, 3) == 0) begin
                        gold_we   = 1'b1;
                        gold_idx  = IW'($urandom_range(0, 15));
                        gold_data = $urandom;
                    end
                end else if ($urandom_range(0, 1) == 1) begin
                    rd_valid = 1'b1;
                end
            end
        end
        idle_inputs();
        if (mode == 0) begin
            chk("done_bound", 64'(fin),     64'd1);
            chk("err_cnt",    64'(err_cnt), 64'(errs));
            chk("pass",       64'(pass),    64'(errs == 0));
            chk("timeout",    64'(timeout), 64'd0);
            chk("end_rd_req", 64'(rd_req),  64'd0);
            chk("end_busy",   64'(busy),    64'd0);
            chk("words_read", 64'(e_idx),   64'(n_words));
`ifdef CHECKER_TRACE_EN
            chk("mm_missing", 64'(exp_mm.size()), 64'd0);
`endif
        end else if (mode == 1) begin
            chk("stall_bound",   64'(fin),     64'd1);
            chk("stall_timeout", 64'(timeout), 64'd1);
            chk("stall_pass",    64'(pass),    64'd0);
            chk("stall_cycle",   64'(edges),   64'(MAXC));
            chk("stall_rd_req",  64'(rd_req),  64'd0);
            chk("stall_reads",   64'(e_idx),   64'd0);
        end
    endtask

    initial begin
        // Reset state
        rst  = 1'b0;
        pc_i = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_cleared("reset");

        // Directed all-pass program, DONE_PC reached around cycle 10
        do_reset();
        n_words = 3;
        gold[0] = 32'd1; gold[1] = 32'd2; gold[2] = 32'd3;
        src[0][0] = 32'd1; src[0][1] = 32'h11111111; src[0][2] = 32'h22222222;
        src[1][0] = 32'd0; src[1][1] = 32'd2;        src[1][2] = 32'd0;
        src[2][0] = 32'd9; src[2][1] = 32'd9;        src[2][2] = 32'd3;
        load_gold();
        while (edges < 9) @(negedge clk);
        run_check(0, 0);
        chk("dir_pass", 64'(pass), 64'd1);

        // Directed single mismatch on word 1
        do_reset();
        src[1][0] = 32'd5; src[1][1] = 32'd6; src[1][2] = 32'd7;
        load_gold();
        run_check(0, 0);
        chk("dir_err_cnt", 64'(err_cnt), 64'd1);

        // Empty golden table finishes immediately without reading
        do_reset();
        pc_i = DPC;
        @(negedge clk);
        chk("empty_done", 64'(done), 64'd1);
        chk("empty_pass", 64'(pass), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("empty_rd_req", 64'(rd_req), 64'd0);
            @(negedge clk);
        end

        // Watchdog with DONE_PC never reached
        do_reset();
        while (edges < int'(MAXC) - 1) @(negedge clk);
        chk("wd_early_timeout", 64'(timeout), 64'd0);
        chk("wd_early_done",    64'(done),    64'd0);
        @(negedge clk);
        chk("wd_timeout", 64'(timeout), 64'd1);
        chk("wd_done",    64'(done),    64'd1);
        chk("wd_pass",    64'(pass),    64'd0);

        // Stalled read source
        do_reset();
        gen_words(2);
        load_gold();
        run_check(1, 0);

        // rd_valid without a request is ignored
        do_reset();
        n_words = 1;
        gold[0] = 32'd5;
        src[0][0] = 32'd5; src[0][1] = 32'd6; src[0][2] = 32'd7;
        load_gold();
        for (int i = 0; i < 3; i++) begin
            rd_valid = 1'b1;
            rd_data  = {NS{32'd7}};
            @(negedge clk);
        end
        idle_inputs();
        chk("ign_err_cnt", 64'(err_cnt), 64'd0);
        chk("ign_rd_req",  64'(rd_req),  64'd0);
        run_check(0, 0);

        // Reset in the middle of a check, then a full rerun
        do_reset();
        gen_words(4);
        src[0][0] = ~gold[0]; src[0][1] = ~gold[0]; src[0][2] = ~gold[0];
        src[2][0] = ~gold[2]; src[2][1] = ~gold[2]; src[2][2] = ~gold[2];
        load_gold();
        run_check(2, 2);
        chk("abort_busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1 check_cleared("abort");
        do_reset();
        load_gold();
        run_check(0, 0);
        chk("rerun_err_cnt", 64'(err_cnt), 64'd2);

        // Randomized programs
        for (int r = 0; r < 20; r++) begin
            do_reset();
            gen_words(int'($urandom_range(1, 6)));
            load_gold();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_check(0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
